trap_entry_return_ctrl: RTL and testbench

//  Sequences trap entry and MRET return for the pipeline. Latches mepc/mcause on an exception,

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_csr_regs.sv | 75 +++++++
 rtl/trap_entry_return_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_entry_return_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap entry/return controller.
// Build option: define TRAP_MTVAL_EN to latch mtval from exc_tval on trap entry.
package trap_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 4;

  localparam logic [XLEN-1:0] HANDLER_BASE = 32'h0000_0080;

  localparam logic [CAUSE_W-1:0] CAUSE_INST_MISALIGN = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL       = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK        = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGN = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_HANDLER = 3'd2,
    ST_RETURN  = 3'd3,
    ST_HALT    = 3'd4
  } trap_state_e;

  // A redirect is outstanding toward fetch in these states.
  function automatic logic is_redirect_state(input trap_state_e st);
    return (st == ST_ENTRY) || (st == ST_RETURN);
  endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// mepc/mcause/mtval storage, written together on trap entry.
// Build option: TRAP_MTVAL_EN enables mtval capture; otherwise mtval reads as zero.
module trap_csr_regs
  import trap_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int CAUSE_W_P = CAUSE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [XLEN_P-1:0]    wr_pc,
  input  logic [CAUSE_W_P-1:0] wr_cause,
  input  logic [XLEN_P-1:0]    wr_tval,
  output logic [XLEN_P-1:0]    mepc,
  output logic [XLEN_P-1:0]    mcause,
  output logic [XLEN_P-1:0]    mtval
);

  logic [XLEN_P-1:0] mepc_q, mepc_d;
  logic [XLEN_P-1:0] mcause_q, mcause_d;
  logic              unused_pc_lsbs;

  // The two low PC bits are forced to zero, so they never reach storage.
  assign unused_pc_lsbs = ^wr_pc[1:0];

  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (wr_en) begin
      mepc_d   = {wr_pc[XLEN_P-1:2], 2'b00};
      mcause_d = {{(XLEN_P-CAUSE_W_P){1'b0}}, wr_cause};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  assign mepc   = mepc_q;
  assign mcause = mcause_q;

`ifdef TRAP_MTVAL_EN
  logic [XLEN_P-1:0] mtval_q, mtval_d;

  always_comb begin
    mtval_d = mtval_q;
    if (wr_en) begin
      mtval_d = wr_tval;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtval_q <= '0;
    end else begin
      mtval_q <= mtval_d;
    end
  end

  assign mtval = mtval_q;
`else
  logic unused_tval;

  assign unused_tval = ^wr_tval;
  assign mtval       = '0;
`endif

endmodule

// File: rtl/trap_entry_return_ctrl.sv
// Trap entry / MRET return sequencer with redirect handshake and double-fault halt.
// Build option: TRAP_MTVAL_EN (passed through to trap_csr_regs) captures mtval.
module trap_entry_return_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int CAUSE_W_P = CAUSE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exc_valid,
  input  logic [CAUSE_W_P-1:0] exc_cause,
  input  logic [XLEN_P-1:0]    exc_pc,
  input  logic [XLEN_P-1:0]    exc_tval,
  input  logic [XLEN_P-1:0]    handler_address,
  input  logic                 mret_valid,
  input  logic                 redirect_ready,
  output logic                 redirect_valid,
  output logic [XLEN_P-1:0]    redirect_target,
  output logic                 flush,
  output logic                 in_trap,
  output logic                 double_fault,
  output logic [XLEN_P-1:0]    mepc,
  output logic [XLEN_P-1:0]    mcause,
  output logic [XLEN_P-1:0]    mtval
);

  trap_state_e       state_q, state_d;
  logic [XLEN_P-1:0] target_q, target_d;
  logic              first_q, first_d;
  logic              csr_wr_en;

  trap_csr_regs #(
    .XLEN_P    (XLEN_P),
    .CAUSE_W_P (CAUSE_W_P)
  ) u_csr (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (csr_wr_en),
    .wr_pc    (exc_pc),
    .wr_cause (exc_cause),
    .wr_tval  (exc_tval),
    .mepc     (mepc),
    .mcause   (mcause),
    .mtval    (mtval)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    csr_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d   = ST_ENTRY;
          target_d  = handler_address;
          csr_wr_en = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (redirect_ready) begin
          state_d = ST_HANDLER;
        end
      end
      // A fault inside the handler beats a simultaneous MRET.
      ST_HANDLER: begin
        if (exc_valid) begin
          state_d = ST_HALT;
        end else if (mret_valid) begin
          state_d  = ST_RETURN;
          target_d = mepc;
        end
      end
      ST_RETURN: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    first_d = (state_d != state_q) && is_redirect_state(state_d);
  end

  always_comb begin
    redirect_valid  = 1'b0;
    redirect_target = '0;
    flush           = 1'b0;
    in_trap         = 1'b0;
    double_fault    = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        redirect_valid  = 1'b1;
        redirect_target = target_q;
        flush           = first_q;
      end
      ST_HANDLER: begin
        in_trap = 1'b1;
      end
      ST_RETURN: begin
        redirect_valid  = 1'b1;
        redirect_target = target_q;
        flush           = first_q;
        in_trap         = 1'b1;
      end
      ST_HALT: begin
        in_trap      = 1'b1;
        double_fault = 1'b1;
      end
      default: begin
        redirect_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_entry_return_ctrl.sv
// Randomized and directed bench for trap_entry_return_ctrl against a behavioural model.
// Honours TRAP_MTVAL_EN the same way the design does.
module tb_trap_entry_return_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic [31:0] handler_address;
  logic        mret_valid;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;
  logic        in_trap;
  logic        double_fault;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: an outstanding redirect (entry or return), handler activity and halt flag.
  bit          m_pending;
  bit          m_first;
  bit          m_is_return;
  bit          m_in_handler;
  bit          m_halted;
  logic [31:0] m_target;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mtval;

  trap_entry_return_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_pc          (exc_pc),
    .exc_tval        (exc_tval),
    .handler_address (handler_address),
    .mret_valid      (mret_valid),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .flush           (flush),
    .in_trap         (in_trap),
    .double_fault    (double_fault),
    .mepc            (mepc),
    .mcause          (mcause),
    .mtval           (mtval)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pending    = 0;
    m_first      = 0;
    m_is_return  = 0;
    m_in_handler = 0;
    m_halted     = 0;
    m_target     = '0;
    m_mepc       = '0;
    m_mcause     = '0;
    m_mtval      = '0;
  endtask

  task automatic model_step(input bit exc, input logic [3:0] cause, input logic [31:0] pc,
                            input logic [31:0] tval, input logic [31:0] handler,
                            input bit mret, input bit ready);
    if (m_halted) begin
      return;
    end
    if (m_pending) begin
      m_first = 0;
      if (ready) begin
        m_pending    = 0;
        m_in_handler = !m_is_return;
      end
    end else if (m_in_handler) begin
      if (exc) begin
        m_halted = 1;
      end else if (mret) begin
        m_pending   = 1;
        m_first     = 1;
        m_is_return = 1;
        m_target    = m_mepc;
      end
    end else if (exc) begin
      m_mepc      = pc & ~32'h3;
      m_mcause    = 32'(cause);
`ifdef TRAP_MTVAL_EN
      m_mtval     = tval;
`endif
      m_pending   = 1;
      m_first     = 1;
      m_is_return = 0;
      m_target    = handler;
    end
  endtask

  task automatic compare_all();
    checkOutput("redirect_valid", 32'(redirect_valid), 32'(m_pending));
    checkOutput("redirect_target", redirect_target, m_pending ? m_target : 32'h0);
    checkOutput("flush", 32'(flush), 32'(m_pending && m_first));
    checkOutput("in_trap", 32'(in_trap), 32'(m_in_handler || m_halted));
    checkOutput("double_fault", 32'(double_fault), 32'(m_halted));
    checkOutput("mepc", mepc, m_mepc);
    checkOutput("mcause", mcause, m_mcause);
    checkOutput("mtval", mtval, m_mtval);
  endtask

  // Check the current cycle's outputs, then drive the inputs sampled at the next edge.
  task automatic applyStimulus(input bit exc, input logic [3:0] cause, input logic [31:0] pc,
                               input logic [31:0] tval, input logic [31:0] handler,
                               input bit mret, input bit ready);
    @(negedge clk);
    compare_all();
    exc_valid       = exc;
    exc_cause       = cause;
    exc_pc          = pc;
    exc_tval        = tval;
    handler_address = handler;
    mret_valid      = mret;
    redirect_ready  = ready;
    model_step(exc, cause, pc, tval, handler, mret, ready);
  endtask

  task automatic clear_inputs();
    exc_valid       = 0;
    exc_cause       = '0;
    exc_pc          = '0;
    exc_tval        = '0;
    handler_address = '0;
    mret_valid      = 0;
    redirect_ready  = 0;
  endtask

  // Reset asserted mid-cycle must drop any redirect without waiting for a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    checkOutput("pre_reset_redirect_valid", 32'(redirect_valid), 32'(m_pending));
    reset = 1;
    #1;
    checkOutput("async_reset_redirect_valid", 32'(redirect_valid), 32'h0);
    model_reset();
    @(negedge clk);
    clear_inputs();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    checkOutput("reset_mepc", mepc, 32'h0);
    reset = 0;

    // MRET while idle is ignored.
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 1, 1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("idle_mret_no_redirect", 32'(redirect_valid), 32'h0);

    // Entry with immediate acceptance.
    applyStimulus(1, 4'd1, 32'h100, 32'hDEAD_BEEF, 32'h84, 0, 1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("t1_target", redirect_target, 32'h84);
    checkOutput("t1_flush", 32'(flush), 32'h1);
    checkOutput("t1_mepc", mepc, 32'h100);
    checkOutput("t1_mcause", mcause, 32'h1);
`ifdef TRAP_MTVAL_EN
    checkOutput("t6_mtval", mtval, 32'hDEAD_BEEF);
`else
    checkOutput("t6_mtval", mtval, 32'h0);
`endif
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("t1_in_trap", 32'(in_trap), 32'h1);

    // MRET back to mepc.
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 1, 1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("t2_target", redirect_target, 32'h100);
    checkOutput("t2_flush", 32'(flush), 32'h1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("t2_hold_flush", 32'(flush), 32'h0);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("t2_in_trap_clear", 32'(in_trap), 32'h0);

    // Redirect held for three cycles of backpressure.
    applyStimulus(1, 4'd2, 32'h200, 32'h0, 32'h88, 0, 0);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 4'd3, 32'h444, 32'h0, 32'h99, 0, 0);
    checkOutput("t3_flush_once", 32'(flush), 32'h0);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("t3_target_stable", redirect_target, 32'h88);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Fault and MRET together inside the handler halts the core.
    applyStimulus(1, 4'd3, 32'h300, 32'h0, 32'h8C, 1, 1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    checkOutput("t4_double_fault", 32'(double_fault), 32'h1);
    checkOutput("t4_mepc_frozen", mepc, 32'h200);
    applyStimulus(1, 4'd1, 32'h500, 32'h0, 32'h84, 1, 1);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1);
    do_reset();

    // Misaligned PC is aligned down; then reset while the entry redirect is pending.
    applyStimulus(1, 4'd0, 32'h103, 32'h1234, 32'h80, 0, 0);
    applyStimulus(0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("t5_mepc_aligned", mepc, 32'h100);
    checkOutput("t5_mcause", mcause, 32'h0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 120) == 0) begin
        do_reset();
      end else begin
        applyStimulus($urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                      32'h80 + 32'($urandom_range(0, 15) << 2),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end
    end
    @(negedge clk);
    compare_all();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
